pingpong_frame_buf: RTL and testbench

PINGPONG_FRAME_BUF -- requirements
Module: pingpong_frame_buf

---
 rtl/pingpong_frame_buf.sv | 78 +++++++
 tb/tb_pingpong_frame_buf.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pingpong_frame_buf.sv
// Double-buffered frame collector: samples fill one bank while the other is presented as a whole frame.
// Define PINGPONG_BITREV_EN to store samples in bit-reversed slot order (FFT input order).
module pingpong_frame_buf #(
  parameter int BUFFER_DEPTH = 16,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [DATA_WIDTH-1:0]            in_data,
  output logic                             in_ready,
  input  logic                             in_abort,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*BUFFER_DEPTH-1:0] out_data,
  output logic [15:0]                      frame_cnt
);
  localparam int AW = $clog2(BUFFER_DEPTH);

  logic [DATA_WIDTH-1:0] bank [2][BUFFER_DEPTH];
  logic [1:0]            full;
  logic                  wr_sel, rd_sel;
  logic [AW-1:0]         wr_idx, wr_slot;
  logic                  accept, xfer, last;

  assign in_ready  = !rst && !full[wr_sel];
  assign accept    = in_valid && in_ready && !in_abort;
  assign out_valid = full[rd_sel];
  assign xfer      = out_valid && out_ready;
  assign last      = (wr_idx == AW'(BUFFER_DEPTH-1));

`ifdef PINGPONG_BITREV_EN
  always_comb begin
    wr_slot = '0;
    for (int i = 0; i < AW; i++) wr_slot[i] = wr_idx[AW-1-i];
  end
`else
  assign wr_slot = wr_idx;
`endif

  // Completion sets full[wr_sel] and release clears full[rd_sel]; these can only
  // coincide on different banks, since the filling bank is never full.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx    <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      full      <= '0;
      frame_cnt <= '0;
    end else begin
      if (in_abort) begin
        wr_idx <= '0;
      end else if (accept) begin
        wr_idx <= wr_idx + 1'b1;
        if (last) begin
          full[wr_sel] <= 1'b1;
          wr_sel       <= ~wr_sel;
        end
      end
      if (xfer) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= ~rd_sel;
        frame_cnt    <= frame_cnt + 16'd1;
      end
    end
  end

  // Storage is not reset; the full flags alone decide what is visible.
  always_ff @(posedge clk) begin
    if (accept) bank[wr_sel][wr_slot] <= in_data;
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < BUFFER_DEPTH; k++)
      out_data[k*DATA_WIDTH +: DATA_WIDTH] = bank[rd_sel][k];
  end
endmodule

// File: tb/tb_pingpong_frame_buf.sv
// Scoreboard bench for pingpong_frame_buf: a queue-of-frames reference model predicts
// in_ready/out_valid/out_data/frame_cnt; directed scenarios plus a random phase.
module tb_pingpong_frame_buf;
  localparam int D  = 16;
  localparam int W  = 32;
  localparam int FW = D*W;

  logic          clk = 1'b0, rst = 1'b1;
  logic          in_valid = 1'b0, in_abort = 1'b0, out_ready = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready, out_valid;
  logic [FW-1:0] out_data;
  logic [15:0]   frame_cnt;

  int nchk = 0, nerr = 0;

  // Reference model: frames completed but not yet delivered, in acceptance order.
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] cur = '0;
  int            k = 0;
  int            n_full = 0;
  logic [15:0]   exp_cnt = '0;
  logic [15:0]   cnt_off = '0;

  pingpong_frame_buf #(.BUFFER_DEPTH(D), .DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .in_abort(in_abort), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic int slot(input int n);
`ifdef PINGPONG_BITREV_EN
    int r = 0;
    for (int b = 0; b < $clog2(D); b++)
      if (n[b]) r = r | (1 << ($clog2(D)-1-b));
    return r;
`else
    return n;
`endif
  endfunction

  // Monitor: compares the presented frame and counter against the model queue.
  always @(negedge clk) begin
    chk("frame_cnt", 64'(frame_cnt), 64'(16'(exp_cnt + cnt_off)));
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    if (!rst && out_valid && exp_q.size() != 0) begin
      nchk++;
      if (out_data !== exp_q[0]) begin
        nerr++;
        $display("FAIL out_data: actual %h required %h", out_data, exp_q[0]);
      end
      if (out_ready) begin
        void'(exp_q.pop_front());
        exp_cnt = exp_cnt + 16'd1;
      end
    end
    if (rst) exp_cnt = '0;
  end

  // Tracker: predicts in_ready and records accepted samples into the model.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      chk("in_ready_rst", 64'(in_ready), 64'(0));
      exp_q.delete();
      n_full = 0;
      k = 0;
    end else begin
      logic rel;
      chk("in_ready", 64'(in_ready), 64'(n_full < 2));
      rel = (n_full > 0) && out_ready;
      if (in_abort) begin
        k = 0;
      end else if (in_valid && n_full < 2) begin
        cur[slot(k)*W +: W] = in_data;
        k++;
        if (k == D) begin
          exp_q.push_back(cur);
          n_full++;
          k = 0;
        end
      end
      if (rel) n_full--;
    end
  end

  task automatic step(input logic v, input logic [W-1:0] d, input logic ab,
                      input logic ordy, output logic acc);
    in_valid = v; in_data = d; in_abort = ab; out_ready = ordy;
    @(negedge clk);
    acc = v && in_ready && !ab;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic ordy);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, ordy, a);
  endtask

  task automatic send_stream(input int n, input logic [W-1:0] base, input logic ordy,
                             output int stalls);
    logic a;
    int   i = 0, guard = 0;
    stalls = 0;
    while (i < n && guard < 200) begin
      step(1'b1, base + W'(i), 1'b0, ordy, a);
      if (a) i++; else stalls++;
      guard++;
    end
    if (i < n) chk("send_timeout", 64'(i), 64'(n));
    in_valid = 1'b0;
  endtask

  initial begin
    logic a;
    int   st;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_valid", 64'(out_valid), 64'(0));
    chk("reset_cnt", 64'(frame_cnt), 64'(0));

    // Single frame, natural or bit-reversed placement
    send_stream(16, 32'h0, 1'b1, st);
    chk("t1_valid", 64'(out_valid), 64'(1));
`ifdef PINGPONG_BITREV_EN
    chk("t1_slot8", 64'(out_data[8*W +: W]), 64'(1));
`else
    chk("t1_slot8", 64'(out_data[8*W +: W]), 64'(8));
`endif
    idle(1, 1'b1);
    chk("t1_cnt", 64'(frame_cnt), 64'(1));
    idle(2, 1'b1);

    // Both banks full, backpressure, single-cycle release
    send_stream(32, 32'h20, 1'b0, st);
    chk("t2_no_stall", 64'(st), 64'(0));
    for (int i = 0; i < 4; i++) step(1'b1, 32'h40, 1'b0, 1'b0, a);
    step(1'b1, 32'h40, 1'b0, 1'b1, a);
    chk("t2_same_cycle", 64'(a), 64'(0));
    chk("t2_ready_next", 64'(in_ready), 64'(1));
    send_stream(16, 32'h40, 1'b0, st);
    idle(4, 1'b1);

    // Continuous back-to-back frames
    send_stream(64, 32'h1000, 1'b1, st);
    chk("t3_no_stall", 64'(st), 64'(0));
    idle(3, 1'b1);

    // Abort mid-frame, then abort at slot 0
    send_stream(5, 32'h80, 1'b1, st);
    step(1'b1, 32'hDEAD, 1'b1, 1'b1, a);
    chk("t4_abort_acc", 64'(a), 64'(0));
    send_stream(16, 32'h100, 1'b1, st);
    idle(3, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1, a);
    send_stream(16, 32'h180, 1'b1, st);
    idle(3, 1'b1);

    // Reset with a frame pending and a partial frame
    send_stream(16, 32'h200, 1'b0, st);
    send_stream(9, 32'h300, 1'b0, st);
    rst = 1'b1;
    step(1'b1, 32'h399, 1'b0, 1'b0, a);
    rst = 1'b0;
    chk("t5_valid", 64'(out_valid), 64'(0));
    chk("t5_cnt", 64'(frame_cnt), 64'(0));
    send_stream(16, 32'h400, 1'b1, st);
    idle(3, 1'b1);

    // Random traffic with aborts and backpressure
    for (int i = 0; i < 800; i++)
      step(($urandom % 4) != 0, $urandom, ($urandom % 25) == 0, ($urandom % 3) != 0, a);
    idle(4, 1'b1);

    // Counter wrap from 0xFFFF
    force dut.frame_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    cnt_off = 16'hFFFF - exp_cnt;
    send_stream(16, 32'h500, 1'b1, st);
    idle(2, 1'b1);
    chk("t7_wrap", 64'(frame_cnt), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end
endmodule
